mux_piso_sequencer: RTL and testbench

- Parallel-in/serial-out sequencer that sits directly upstream of the 8:1 mux.
- Accepts an 8-bit word over a valid/ready handshake and holds it on the mux data inputs.
- Steps the mux 3-bit select through all 8 positions, then registers the mux output into a framed serial bitstream.
- The mux itself stays external; this block drives its i/s inputs and consumes its y output.

---
 rtl/mux_piso_sequencer.sv | 152 +++++++++++++++
 tb/tb_mux_piso_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_piso_sequencer.sv
// mux_piso_sequencer: parallel-in/serial-out sequencer for an external 8:1 mux.
// It captures a byte into mux_i, walks mux_s over all eight positions, and
// registers mux_y into a framed serial stream (ser_out/ser_valid/first/last).
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready;
// in_ready is high only in IDLE and never during reset; there is no buffering,
// so a word offered while busy is simply ignored.
//
// Optional feature: define MUX_PISO_PARITY_EN to append an even-parity bit
// (XOR of the eight sampled bits) as a ninth frame bit.
module mux_piso_sequencer #(
    parameter bit          MSB_FIRST  = 1'b0,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] mux_i,
    output logic [2:0] mux_s,
    input  logic       mux_y,
    output logic       ser_out,
    output logic       ser_valid,
    output logic       ser_first,
    output logic       ser_last,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [2:0] START_SEL = MSB_FIRST ? 3'd7 : 3'd0;
    // Last value of the gap counter before returning to IDLE.
    localparam logic [3:0] GAP_LAST  = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] bit_cnt;
    logic [3:0] gap_cnt;
    logic       accept;
    logic       last_bit;

    assign in_ready = (state == IDLE) && rst_n;
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;
    assign last_bit = (bit_cnt == 3'd7);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: IDLE -> SHIFT x8 -> (PAR) -> (GAP) -> IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = SHIFT;
            SHIFT: begin
                if (last_bit) begin
`ifdef MUX_PISO_PARITY_EN
                    state_nxt = PAR;
`else
                    state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
`endif
                end
            end
            PAR:   state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:   if (gap_cnt == GAP_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Word capture, select stepping and bit/gap counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_i   <= 8'h00;
            mux_s   <= 3'd0;
            bit_cnt <= 3'd0;
            gap_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mux_i   <= in_data;
                        mux_s   <= START_SEL;
                        bit_cnt <= 3'd0;
                    end
                end
                SHIFT: begin
                    gap_cnt <= 4'd0;
                    // Select holds on the final position once the frame data is done.
                    if (!last_bit) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        mux_s   <= MSB_FIRST ? (mux_s - 3'd1) : (mux_s + 3'd1);
                    end
                end
                PAR:     gap_cnt <= 4'd0;
                GAP:     gap_cnt <= gap_cnt + 4'd1;
                default: gap_cnt <= 4'd0;
            endcase
        end
    end

`ifdef MUX_PISO_PARITY_EN
    logic parity_acc;

    // Running XOR of the sampled mux bits; cleared when a new word is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                parity_acc <= 1'b0;
        else if (accept)           parity_acc <= 1'b0;
        else if (state == SHIFT)   parity_acc <= parity_acc ^ mux_y;
    end
`endif

    // Serial output register: one cycle behind the select that produced the bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            ser_first <= 1'b0;
            ser_last  <= 1'b0;
        end else begin
            ser_valid <= 1'b0;
            ser_first <= 1'b0;
            ser_last  <= 1'b0;
            if (state == SHIFT) begin
                ser_out   <= mux_y;
                ser_valid <= 1'b1;
                ser_first <= (bit_cnt == 3'd0);
`ifdef MUX_PISO_PARITY_EN
                ser_last  <= 1'b0;
`else
                ser_last  <= last_bit;
`endif
            end
`ifdef MUX_PISO_PARITY_EN
            else if (state == PAR) begin
                ser_out   <= parity_acc;
                ser_valid <= 1'b1;
                ser_last  <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mux_piso_sequencer.sv
// Directed bench for mux_piso_sequencer. Three instances share the input
// stimulus: a (LSB first, gap 2), b (MSB first, gap 2), c (LSB first, gap 0),
// each with its own behavioural 8:1 mux closing the i/s -> y loop.
module tb_mux_piso_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;

    logic       a_rdy, a_y, a_so, a_sv, a_sf, a_sl, a_busy;
    logic [7:0] a_i;
    logic [2:0] a_s;
    logic       b_rdy, b_y, b_so, b_sv, b_sf, b_sl, b_busy;
    logic [7:0] b_i;
    logic [2:0] b_s;
    logic       c_rdy, c_y, c_so, c_sv, c_sf, c_sl, c_busy;
    logic [7:0] c_i;
    logic [2:0] c_s;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef MUX_PISO_PARITY_EN
    localparam int FRAME_BITS = 9;
`else
    localparam int FRAME_BITS = 8;
`endif

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs and mux models ----------------
    assign a_y = a_i[a_s];
    assign b_y = b_i[b_s];
    assign c_y = c_i[c_s];

    mux_piso_sequencer #(.MSB_FIRST(1'b0), .GAP_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(a_rdy), .mux_i(a_i), .mux_s(a_s), .mux_y(a_y),
        .ser_out(a_so), .ser_valid(a_sv), .ser_first(a_sf), .ser_last(a_sl),
        .busy(a_busy));

    mux_piso_sequencer #(.MSB_FIRST(1'b1), .GAP_CYCLES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(b_rdy), .mux_i(b_i), .mux_s(b_s), .mux_y(b_y),
        .ser_out(b_so), .ser_valid(b_sv), .ser_first(b_sf), .ser_last(b_sl),
        .busy(b_busy));

    mux_piso_sequencer #(.MSB_FIRST(1'b0), .GAP_CYCLES(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(c_rdy), .mux_i(c_i), .mux_s(c_s), .mux_y(c_y),
        .ser_out(c_so), .ser_valid(c_sv), .ser_first(c_sf), .ser_last(c_sl),
        .busy(c_busy));

    // ---------------- driver / check tasks ----------------
    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send one word with all instances idle and check the full frame.
    task automatic send_and_check(input logic [7:0] w);
        in_data  = w;
        in_valid = 1'b1;
        step();                     // accept edge
        in_valid = 1'b0;
        in_data  = ~w;              // must be ignored while busy
        chk("cap_a_mux_i", a_i, w);
        chk("cap_b_mux_i", b_i, w);
        chk("cap_a_busy", a_busy, 1);
        chk("cap_a_in_ready", a_rdy, 0);
        chk("cap_a_ser_valid", a_sv, 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("a_mux_s%0d", i), a_s, i);
            chk($sformatf("b_mux_s%0d", i), b_s, 7 - i);
            step();
            chk($sformatf("a_bit%0d", i), a_so, w[i]);
            chk($sformatf("b_bit%0d", i), b_so, w[7 - i]);
            chk($sformatf("c_bit%0d", i), c_so, w[i]);
            chk($sformatf("a_valid%0d", i), a_sv, 1);
            chk($sformatf("a_first%0d", i), a_sf, (i == 0));
            chk($sformatf("a_last%0d", i), a_sl, (FRAME_BITS == 8 && i == 7));
        end
`ifdef MUX_PISO_PARITY_EN
        step();
        chk("a_parity", a_so, ^w);
        chk("b_parity", b_so, ^w);
        chk("a_par_valid", a_sv, 1);
        chk("a_par_last", a_sl, 1);
        chk("a_par_first", a_sf, 0);
`endif
        chk("c_ready_after_frame", c_rdy, 1);
        step();
        chk("a_valid_drop", a_sv, 0);
        chk("a_last_drop", a_sl, 0);
        chk("a_ready_in_gap", a_rdy, 0);
        chk("a_mux_s_hold", a_s, 7);
        chk("b_mux_s_hold", b_s, 0);
        chk("a_mux_i_hold", a_i, w);
        step();
        chk("a_ready_back", a_rdy, 1);
        chk("b_ready_back", b_rdy, 1);
        chk("a_busy_back", a_busy, 0);
    endtask

    // ---------------- scoreboard + sequence ----------------
    logic [0:0] exp_q[$];

    initial begin
        logic [7:0] word;
        int first1, first2, nbits;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Reset for 3 cycles.
        repeat (3) step();
        chk("rst_in_ready", a_rdy, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_ser_valid", a_sv, 0);
        chk("rst_mux_i", a_i, 8'h00);
        chk("rst_mux_s", a_s, 3'd0);
        chk("rst_ser_out", a_so, 0);
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", a_rdy, 1);
        chk("idle_b_in_ready", b_rdy, 1);
        repeat (2) step();
        chk("idle_ser_valid", a_sv, 0);
        chk("idle_ser_first", a_sf, 0);
        chk("idle_busy", a_busy, 0);

        // Directed frames.
        send_and_check(8'hA5);
        send_and_check(8'h01);
        send_and_check(8'h07);
        send_and_check(8'h03);

        // Back-to-back on the zero-gap instance: FF then 00.
        word = 8'hFF;
        for (int i = 0; i < 8; i++) exp_q.push_back(word[i]);
        if (FRAME_BITS == 9) exp_q.push_back(^word);
        word = 8'h00;
        for (int i = 0; i < 8; i++) exp_q.push_back(word[i]);
        if (FRAME_BITS == 9) exp_q.push_back(^word);
        first1 = -1;
        first2 = -1;
        nbits  = 0;
        in_data  = 8'hFF;
        in_valid = 1'b1;
        step();
        in_data = 8'h00;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            step();
            if (c_sv) begin
                nbits++;
                if (exp_q.size() > 0) chk($sformatf("b2b_bit%0d", nbits), c_so, exp_q.pop_front());
                else                  chk("b2b_extra_bit", nbits, 2 * FRAME_BITS);
                if (c_sf) begin
                    if (first1 < 0) first1 = cyc;
                    else if (first2 < 0) begin
                        first2   = cyc;
                        in_valid = 1'b0;
                    end
                end
            end
        end
        in_valid = 1'b0;
        chk("b2b_nbits", nbits, 2 * FRAME_BITS);
        chk("b2b_first1", first1, 1);
        chk("b2b_period", first2 - first1, FRAME_BITS + 1);

        // Reset mid-frame after bit 3 of 3C.
        in_data  = 8'h3C;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("mid_bit3", a_so, 1);
        chk("mid_valid", a_sv, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", a_sv, 0);
        chk("mid_rst_busy", a_busy, 0);
        chk("mid_rst_last", a_sl, 0);
        chk("mid_rst_mux_i", a_i, 8'h00);
        chk("mid_rst_c_busy", c_busy, 0);
        step();
        rst_n = 1'b1;
        step();
        send_and_check(8'h81);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
